// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (DM).
// Fixed DM priority with an anti-starvation counter that forces an IF grant.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [DATA_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic [3:0]            dm_be,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [3:0]            mem_byte_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {PRIO_DM, PRIO_IF} prio_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;

  prio_e          prio_q, prio_d;
  owner_e         owner_q, owner_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           if_win, dm_win;

  // Grants are gated by reset so the bus is silent while arst_n is low.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (arst_n) begin
      if (if_req && dm_req) begin
        if (prio_q == PRIO_IF) if_win = 1'b1;
        else                   dm_win = 1'b1;
      end else begin
        if_win = if_req;
        dm_win = dm_req;
      end
    end
  end

  assign if_gnt = if_win;
  assign dm_gnt = dm_win;

  always_comb begin
    mem_en       = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_byte_en  = '0;
    if (if_win) begin
      mem_en      = 1'b1;
      mem_addr    = if_addr;
      mem_byte_en = 4'hF;
    end else if (dm_win) begin
      mem_en       = 1'b1;
      mem_write_en = dm_we;
      mem_addr     = dm_addr;
      mem_data_in  = dm_wdata;
      mem_byte_en  = dm_we ? dm_be : 4'hF;
    end
  end

  always_comb begin
    wait_d  = wait_q;
    prio_d  = prio_q;
    owner_d = OWN_NONE;

    if (if_win || !if_req)              wait_d = '0;
    else if (wait_q != WW'(MAX_WAIT))   wait_d = wait_q + 1'b1;

    // Switch on the denial that makes the count reach MAX_WAIT, so IF wins the very next cycle.
    case (prio_q)
      PRIO_DM: if (if_req && !if_win && (wait_d == WW'(MAX_WAIT))) prio_d = PRIO_IF;
      PRIO_IF: if (if_win) prio_d = PRIO_DM;
      default: prio_d = PRIO_DM;
    endcase

    if (if_win)                owner_d = OWN_IF;
    else if (dm_win && !dm_we) owner_d = OWN_DM;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      prio_q  <= PRIO_DM;
      owner_q <= OWN_NONE;
      wait_q  <= '0;
    end else begin
      prio_q  <= prio_d;
      owner_q <= owner_d;
      wait_q  <= wait_d;
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign dm_rvalid = (owner_q == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_data_out : '0;
  assign dm_rdata  = dm_rvalid ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: driver runs a reference model and queues
// expected grants/responses; a negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam int unsigned MW   = 4;
  localparam int unsigned NPOOL = 16;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_en, mem_write_en;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic [3:0]  mem_byte_en;

  mem_arbiter #(.DATA_WIDTH(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .arst_n(arst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_byte_en(mem_byte_en), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Address pool: 0x10..0x2C and 0x8E00_0000..0x8E00_001C.
  function automatic logic [31:0] pool_addr(input int unsigned k);
    if (k < 8) return 32'h0000_0010 + 32'(4 * k);
    return 32'h8E00_0000 + 32'(4 * (k - 8));
  endfunction

  function automatic int pidx(input logic [31:0] a);
    for (int unsigned k = 0; k < NPOOL; k++)
      if (pool_addr(k) == a) return int'(k);
    return -1;
  endfunction

  // Memory attached to the DUT bus; returns garbage whenever no read was issued.
  logic [31:0] phys_mem [NPOOL];
  logic [31:0] ref_mem  [NPOOL];

  always @(posedge clk) begin
    if (mem_en && mem_write_en) begin
      if (pidx(mem_addr) >= 0)
        for (int b = 0; b < 4; b++)
          if (mem_byte_en[b]) phys_mem[pidx(mem_addr)][8*b +: 8] <= mem_data_in[8*b +: 8];
      mem_data_out <= $urandom;
    end else if (mem_en) begin
      mem_data_out <= (pidx(mem_addr) >= 0) ? phys_mem[pidx(mem_addr)] : 32'hBAD0_BAD0;
    end else begin
      mem_data_out <= $urandom;
    end
  end

  typedef struct {
    int          cyc;
    logic        ig, dg, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t if_q[$];
  rsp_t dm_q[$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // Reference arbitration state: consecutive IF denials and the sticky "IF owed a grant" flag.
  int denied = 0;
  bit forced = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [3:0] dbe,
                       output logic ig, output logic dg);
    gnt_t        g;
    logic [31:0] mask;
    int          ii, di;
    if_req = ir; if_addr = ia;
    dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dwd; dm_be = dbe;

    ig = ir && (!dr || forced);
    dg = dr && !ig;

    g.cyc   = cyc;
    g.ig    = ig;
    g.dg    = dg;
    g.we    = dw;
    g.addr  = ig ? ia : (dg ? da : 32'h0);
    g.wdata = (dg && dw) ? dwd : 32'h0;
    g.be    = (dg && dw) ? dbe : ((ig || dg) ? 4'hF : 4'h0);
    gnt_q.push_back(g);

    ii = pidx(ia);
    di = pidx(da);
    if (ig) if_q.push_back('{cyc + 1, ref_mem[ii]});
    if (dg && !dw) dm_q.push_back('{cyc + 1, ref_mem[di]});
    if (dg && dw) begin
      mask = {{8{dbe[3]}}, {8{dbe[2]}}, {8{dbe[1]}}, {8{dbe[0]}}};
      ref_mem[di] = (ref_mem[di] & ~mask) | (dwd & mask);
    end

    if (ig) begin
      denied = 0;
      forced = 1'b0;
    end else if (ir) begin
      denied = (denied + 1 > int'(MW)) ? int'(MW) : denied + 1;
      if (denied == int'(MW)) forced = 1'b1;
    end else begin
      denied = 0;
    end
  endtask

  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [31:0] dwd, input logic [3:0] dbe,
                      output logic ig, output logic dg);
    @(posedge clk);
    #1;
    apply(ir, ia, dr, dw, da, dwd, dbe, ig, dg);
  endtask

  always @(negedge clk) begin
    gnt_t g;
    rsp_t r;
    if (mon_en) begin
      if (gnt_q.size() == 0 || gnt_q[0].cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL gnt_sched: no expectation queued for cycle %0d", cyc);
      end else begin
        g = gnt_q.pop_front();
        check("if_gnt", if_gnt, g.ig);
        check("dm_gnt", dm_gnt, g.dg);
        check("mem_en", mem_en, g.ig | g.dg);
        check("mem_write_en", mem_write_en, g.dg & g.we);
        check("mem_addr", mem_addr, g.addr);
        check("mem_byte_en", mem_byte_en, g.be);
        if (!(g.ig || g.dg) || (g.dg && g.we)) check("mem_data_in", mem_data_in, g.wdata);
      end
      if (if_q.size() != 0 && if_q[0].cyc == cyc) begin
        r = if_q.pop_front();
        check("if_rvalid", if_rvalid, 1);
        check("if_rdata", if_rdata, r.data);
      end else begin
        check("if_rvalid_idle", if_rvalid, 0);
        check("if_rdata_idle", if_rdata, 0);
      end
      if (dm_q.size() != 0 && dm_q[0].cyc == cyc) begin
        r = dm_q.pop_front();
        check("dm_rvalid", dm_rvalid, 1);
        check("dm_rdata", dm_rdata, r.data);
      end else begin
        check("dm_rvalid_idle", dm_rvalid, 0);
        check("dm_rdata_idle", dm_rdata, 0);
      end
    end
  end

  initial begin
    logic        ig, dg;
    logic        cir, cdr, cdw;
    logic [31:0] cia, cda, cdwd;
    logic [3:0]  cbe;

    for (int unsigned k = 0; k < NPOOL; k++) begin
      phys_mem[k] = $urandom;
      ref_mem[k]  = phys_mem[k];
    end

    arst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;

    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h10; dm_addr = 32'h14;
    #1;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_dm_gnt", dm_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_write_en", mem_write_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_byte_en", mem_byte_en, 0);
    check("rst_rvalid", {if_rvalid, dm_rvalid}, 0);
    check("rst_rdata", {if_rdata, dm_rdata}, 0);

    @(posedge clk);
    #1;
    arst_n = 1'b1;
    mon_en = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // Fetch only
    step(1, 32'h10, 0, 0, 0, 0, 0, ig, dg);
    #1;
    check("dir_if_gnt", if_gnt, 1);
    check("dir_if_addr", mem_addr, 32'h10);
    check("dir_if_we", mem_write_en, 0);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // Full-word store
    step(0, 0, 1, 1, 32'h8E00_0000, 32'hDEAD_BEEF, 4'hF, ig, dg);
    #1;
    check("dir_st_gnt", dm_gnt, 1);
    check("dir_st_we", mem_write_en, 1);
    check("dir_st_addr", mem_addr, 32'h8E00_0000);
    check("dir_st_data", mem_data_in, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // Back-to-back: fetch then load of the stored word
    step(1, 32'h14, 0, 0, 0, 0, 0, ig, dg);
    step(0, 0, 1, 0, 32'h8E00_0000, 0, 4'h0, ig, dg);
    #1;
    check("b2b_if_rvalid", if_rvalid, 1);
    check("b2b_dm_gnt", dm_gnt, 1);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    #1;
    check("b2b_dm_rvalid", dm_rvalid, 1);
    check("b2b_dm_rdata", dm_rdata, 32'hDEAD_BEEF);

    // Contention: IF wins every (MAX_WAIT+1)th cycle
    for (int k = 0; k < 10; k++) begin
      step(1, 32'h18, 1, 0, 32'h8E00_0004, 0, 4'h0, ig, dg);
      #1;
      check("contention_if_gnt", if_gnt, (k % 5) == 4);
    end
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);

    // Random traffic with a mid-load reset in the middle
    cir = 1'b0; cdr = 1'b0; cdw = 1'b0;
    cia = pool_addr(0); cda = pool_addr(8); cdwd = '0; cbe = 4'hF;
    for (int n = 0; n < 800; n++) begin
      if (n == 400) begin
        step(0, 0, 1, 0, pool_addr(9), 0, 4'h0, ig, dg);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
        #1;
        check("pre_reset_dm_rvalid", dm_rvalid, 1);
        arst_n = 1'b0;
        #1;
        check("async_rst_dm_rvalid", dm_rvalid, 0);
        check("async_rst_gnt", {if_gnt, dm_gnt}, 0);
        check("async_rst_mem_en", mem_en, 0);
        gnt_q.delete(); if_q.delete(); dm_q.delete();
        denied = 0; forced = 1'b0;
        cir = 1'b0; cdr = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        mon_en = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, ig, dg);
      end
      if (!cir) begin
        if ($urandom_range(0, 2) != 0) begin
          cir = 1'b1;
          cia = pool_addr($urandom_range(0, NPOOL - 1));
        end
      end else if ($urandom_range(0, 15) == 0) begin
        cir = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        cia = pool_addr($urandom_range(0, NPOOL - 1));
      end
      if (!cdr) begin
        if ($urandom_range(0, 2) != 0) begin
          cdr  = 1'b1;
          cdw  = $urandom_range(0, 1) == 1;
          cda  = pool_addr($urandom_range(0, NPOOL - 1));
          cdwd = $urandom;
          cbe  = 4'($urandom_range(1, 15));
        end
      end else if ($urandom_range(0, 15) == 0) begin
        cdr = 1'b0;
      end
      step(cir, cia, cdr, cdw, cda, cdwd, cbe, ig, dg);
      if (ig) cir = 1'b0;
      if (dg) cdr = 1'b0;
    end

    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    @(negedge clk);
    #1;
    check("leftover_expectations", gnt_q.size() + if_q.size() + dm_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
